// File: rtl/msrh_lsu_pkg.sv
// Shared LSU types for the parametrised load-queue entry.
// The replay-limit feature is enabled by defining MSRH_LDQ_RETRY_LIMIT_EN.
package msrh_lsu_pkg;

   localparam int unsigned BR_MAX_W = 32;

   typedef enum logic [3:0] {
      StInit         = 4'd0,
      StIssueWait    = 4'd1,
      StIssued       = 4'd2,
      StTlbHaz       = 4'd3,
      StEx2Run       = 4'd4,
      StLrqHaz       = 4'd5,
      StStqHaz       = 4'd6,
      StEx3Done      = 4'd7,
      StWaitComplete = 4'd8,
      StDead         = 4'd9
   } ldq_state_t;

   typedef enum logic [2:0] {
      HazNone        = 3'd0,
      HazL1dConflict = 3'd1,
      HazLrqConflict = 3'd2,
      HazLrqFull     = 3'd3,
      HazStqDepend   = 3'd4,
      HazLrqAssigned = 3'd5
   } ex2_haz_t;

   typedef struct packed {
      logic       valid;
      ldq_state_t state;
      logic       oldest_only;
   } ldq_mp_entry_t;

   // Masks narrower than BR_MAX_W are zero-extended by the caller.
   function automatic logic is_br_flush_target(input logic [BR_MAX_W-1:0] br_mask,
                                                input logic [4:0]          br_tag,
                                                input logic                br_update,
                                                input logic                br_mispredict);
      return br_update & br_mispredict & br_mask[br_tag];
   endfunction

endpackage

// File: rtl/msrh_rnid_wakeup.sv
// Matches one source rename ID against every physical write-back bus.
// Used by msrh_ldq_entry_mp (MSRH_LDQ_RETRY_LIMIT_EN has no effect here).
module msrh_rnid_wakeup #(
   parameter int unsigned WR_BUS = 4,
   parameter int unsigned RNID_W = 7
) (
   input  logic [RNID_W-1:0]        i_rnid,
   input  logic [WR_BUS-1:0]        i_wr_valid,
   input  logic [WR_BUS*RNID_W-1:0] i_wr_rnid,
   output logic                     o_hit
);

   always_comb begin
      o_hit = 1'b0;
      for (int b = 0; b < WR_BUS; b++) begin
         if (i_wr_valid[b] && (i_wr_rnid[b*RNID_W +: RNID_W] == i_rnid)) o_hit = 1'b1;
      end
   end

endmodule

// File: rtl/msrh_ldq_entry_mp.sv
// One LDQ slot: tracks a load from dispatch through issue, EX1/EX2 replay and commit.
// Define MSRH_LDQ_RETRY_LIMIT_EN to enable the replay counter and oldest-only escalation.
module msrh_ldq_entry_mp
   import msrh_lsu_pkg::*;
#(
   parameter int unsigned PIPE_NUM  = 2,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned WR_BUS    = 4,
   parameter int unsigned RNID_W    = 7,
   parameter int unsigned CMT_ID_W  = 6,
   parameter int unsigned DISP_SIZE = 4,
   parameter int unsigned BR_W      = 4,
   parameter int unsigned LRQ_SIZE  = 8,
   parameter int unsigned STQ_SIZE  = 16,
   parameter int unsigned RETRY_W   = 3,
   parameter int unsigned RETRY_MAX = 6,
   localparam int unsigned BR_TAG_W = (BR_W > 1) ? $clog2(BR_W) : 1
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_disp_valid,
   input  logic [CMT_ID_W-1:0]         i_disp_cmt_id,
   input  logic [DISP_SIZE-1:0]        i_disp_grp_id,
   input  logic [BR_W-1:0]             i_disp_br_mask,
   input  logic [PIPE_NUM-1:0]         i_disp_pipe_sel_oh,
   input  logic [NUM_SRC-1:0]          i_disp_rs_valid,
   input  logic [NUM_SRC-1:0]          i_disp_rs_ready,
   input  logic [NUM_SRC*RNID_W-1:0]   i_disp_rs_rnid,
   input  logic [WR_BUS-1:0]           i_phy_wr_valid,
   input  logic [WR_BUS*RNID_W-1:0]    i_phy_wr_rnid,
   input  logic                        i_picked,
   input  logic                        i_is_oldest,
   input  logic                        i_ex1_valid,
   input  logic                        i_ex1_tlb_haz,
   input  logic [PIPE_NUM-1:0]         i_tlb_resolve,
   input  logic                        i_ex2_valid,
   input  logic [2:0]                  i_ex2_haz_typ,
   input  logic [LRQ_SIZE-1:0]         i_ex2_lrq_oh,
   input  logic [STQ_SIZE-1:0]         i_ex2_stq_haz,
   input  logic                        i_lrq_resolve_valid,
   input  logic [LRQ_SIZE-1:0]         i_lrq_resolve_oh,
   input  logic                        i_stq_resolve_valid,
   input  logic [STQ_SIZE-1:0]         i_stq_resolve_oh,
   input  logic                        i_commit_valid,
   input  logic [CMT_ID_W-1:0]         i_commit_cmt_id,
   input  logic                        i_commit_flush,
   input  logic                        i_br_update,
   input  logic                        i_br_mispredict,
   input  logic [BR_TAG_W-1:0]         i_br_tag,
   output logic                        o_valid,
   output logic                        o_ready,
   output logic [3:0]                  o_state,
   output logic [PIPE_NUM-1:0]         o_pipe_sel_oh,
   output logic [PIPE_NUM-1:0]         o_ex2_recv,
   output logic [RETRY_W-1:0]          o_replay_cnt,
   output logic                        o_oldest_only,
   output logic                        o_finish
);

   ldq_mp_entry_t               entry_q, entry_d;
   logic [CMT_ID_W-1:0]         cmt_id_q, cmt_id_d;
   logic [DISP_SIZE-1:0]        grp_id_q, grp_id_d;
   logic [BR_W-1:0]             br_mask_q, br_mask_d;
   logic [PIPE_NUM-1:0]         pipe_sel_q, pipe_sel_d;
   logic [NUM_SRC-1:0]          rs_valid_q, rs_valid_d;
   logic [NUM_SRC-1:0]          rs_ready_q, rs_ready_d;
   logic [NUM_SRC*RNID_W-1:0]   rs_rnid_q, rs_rnid_d;
   logic [LRQ_SIZE-1:0]         lrq_oh_q, lrq_oh_d;
   logic [STQ_SIZE-1:0]         stq_haz_q, stq_haz_d;
   logic [PIPE_NUM-1:0]         ex2_recv_q, ex2_recv_d;

   logic [NUM_SRC*RNID_W-1:0]   wake_rnid;
   logic [NUM_SRC-1:0]          rs_wake;
   logic [STQ_SIZE-1:0]         stq_masked;
   logic                        flush, disp_br_kill, oldest_ok, replay, free;

   // During dispatch the incoming IDs are compared so a same-cycle write-back is not lost.
   assign wake_rnid = (entry_q.state == StInit) ? i_disp_rs_rnid : rs_rnid_q;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      msrh_rnid_wakeup #(
         .WR_BUS (WR_BUS),
         .RNID_W (RNID_W)
      ) u_wakeup (
         .i_rnid     (wake_rnid[s*RNID_W +: RNID_W]),
         .i_wr_valid (i_phy_wr_valid),
         .i_wr_rnid  (i_phy_wr_rnid),
         .o_hit      (rs_wake[s])
      );
   end

   assign disp_br_kill = is_br_flush_target(BR_MAX_W'(i_disp_br_mask), 5'(i_br_tag),
                                            i_br_update, i_br_mispredict);
   assign flush = entry_q.valid &&
                  !(entry_q.state inside {StInit, StWaitComplete, StDead}) &&
                  (i_commit_flush ||
                   is_br_flush_target(BR_MAX_W'(br_mask_q), 5'(i_br_tag),
                                      i_br_update, i_br_mispredict));

`ifdef MSRH_LDQ_RETRY_LIMIT_EN
   assign oldest_ok = !entry_q.oldest_only || i_is_oldest;
`else
   assign oldest_ok = 1'b1;
`endif

   assign o_ready  = (entry_q.state == StIssueWait) && (&(rs_ready_q | ~rs_valid_q)) &&
                     !flush && oldest_ok;
   assign o_finish = entry_q.valid && (entry_q.state inside {StWaitComplete, StDead}) &&
                     i_commit_valid && (i_commit_cmt_id == cmt_id_q);
   assign stq_masked = stq_haz_q & ~(i_stq_resolve_valid ? i_stq_resolve_oh : '0);

   always_comb begin
      entry_d    = entry_q;
      cmt_id_d   = cmt_id_q;
      grp_id_d   = grp_id_q;
      pipe_sel_d = pipe_sel_q;
      rs_valid_d = rs_valid_q;
      rs_rnid_d  = rs_rnid_q;
      rs_ready_d = rs_ready_q | rs_wake;
      lrq_oh_d   = lrq_oh_q;
      stq_haz_d  = stq_haz_q;
      ex2_recv_d = ex2_recv_q;
      br_mask_d  = br_mask_q;
      replay     = 1'b0;
      free       = 1'b0;

      if (flush) begin
         entry_d.state = StDead;
         ex2_recv_d    = '0;
      end else begin
         unique case (entry_q.state)
            StInit: if (i_disp_valid) begin
               entry_d.valid = 1'b1;
               entry_d.state = disp_br_kill ? StDead : StIssueWait;
               cmt_id_d      = i_disp_cmt_id;
               grp_id_d      = i_disp_grp_id;
               pipe_sel_d    = i_disp_pipe_sel_oh;
               rs_valid_d    = i_disp_rs_valid;
               rs_rnid_d     = i_disp_rs_rnid;
               rs_ready_d    = i_disp_rs_ready | rs_wake;
               br_mask_d     = i_disp_br_mask;
               ex2_recv_d    = '0;
            end
            StIssueWait: if (o_ready && i_picked) entry_d.state = StIssued;
            StIssued: if (i_ex1_valid) begin
               if (i_ex1_tlb_haz) begin
                  entry_d.state = StTlbHaz;
               end else begin
                  entry_d.state = StEx2Run;
                  ex2_recv_d    = pipe_sel_q;
               end
            end
            StTlbHaz: if (|i_tlb_resolve) begin
               entry_d.state = StIssueWait;
               replay        = 1'b1;
            end
            StEx2Run: if (i_ex2_valid) begin
               ex2_recv_d = '0;
               case (ex2_haz_t'(i_ex2_haz_typ))
                  HazNone: entry_d.state = StEx3Done;
                  HazLrqConflict, HazLrqFull: begin
                     if ((ex2_haz_t'(i_ex2_haz_typ) == HazLrqConflict) && i_lrq_resolve_valid &&
                         |(i_ex2_lrq_oh & i_lrq_resolve_oh)) begin
                        entry_d.state = StIssueWait;
                        replay        = 1'b1;
                     end else begin
                        entry_d.state = StLrqHaz;
                        lrq_oh_d      = i_ex2_lrq_oh;
                     end
                  end
                  HazStqDepend: begin
                     entry_d.state = StStqHaz;
                     stq_haz_d     = i_ex2_stq_haz;
                  end
                  default: begin
                     entry_d.state = StIssueWait;
                     replay        = 1'b1;
                  end
               endcase
            end
            StLrqHaz: if (i_lrq_resolve_valid && |(i_lrq_resolve_oh & lrq_oh_q)) begin
               entry_d.state = StIssueWait;
               replay        = 1'b1;
            end
            StStqHaz: begin
               stq_haz_d = stq_masked;
               if (stq_masked == '0) begin
                  entry_d.state = StIssueWait;
                  replay        = 1'b1;
               end
            end
            StEx3Done: entry_d.state = StWaitComplete;
            StWaitComplete, StDead: free = o_finish;
            default: entry_d.state = StInit;
         endcase
      end

      if (i_br_update) br_mask_d[i_br_tag] = 1'b0;
      if (free) begin
         entry_d.valid = 1'b0;
         entry_d.state = StInit;
      end
      entry_d.oldest_only = 1'b0;
   end

`ifdef MSRH_LDQ_RETRY_LIMIT_EN
   logic [RETRY_W-1:0] replay_cnt_q, replay_cnt_d;
   logic               cnt_clr;

   assign cnt_clr = free || ((entry_q.state == StInit) && i_disp_valid);

   always_comb begin
      replay_cnt_d = replay_cnt_q;
      if (cnt_clr) replay_cnt_d = '0;
      else if (replay && (replay_cnt_q != '1)) replay_cnt_d = replay_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) replay_cnt_q <= '0;
      else         replay_cnt_q <= replay_cnt_d;
   end

   // Escalation is sticky: only freeing or redispatching the slot clears it.
   logic oldest_only_d;
   assign oldest_only_d = (!cnt_clr && entry_q.oldest_only) ||
                          (replay_cnt_d >= RETRY_W'(RETRY_MAX));
   assign o_replay_cnt  = replay_cnt_q;
`else
   logic oldest_only_d;
   assign oldest_only_d = entry_d.oldest_only;
   assign o_replay_cnt  = '0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         entry_q    <= '{valid: 1'b0, state: StInit, oldest_only: 1'b0};
         cmt_id_q   <= '0;
         grp_id_q   <= '0;
         br_mask_q  <= '0;
         pipe_sel_q <= '0;
         rs_valid_q <= '0;
         rs_ready_q <= '0;
         rs_rnid_q  <= '0;
         lrq_oh_q   <= '0;
         stq_haz_q  <= '0;
         ex2_recv_q <= '0;
      end else begin
         entry_q.valid       <= entry_d.valid;
         entry_q.state       <= entry_d.state;
         entry_q.oldest_only <= oldest_only_d;
         cmt_id_q            <= cmt_id_d;
         grp_id_q            <= grp_id_d;
         br_mask_q           <= br_mask_d;
         pipe_sel_q          <= pipe_sel_d;
         rs_valid_q          <= rs_valid_d;
         rs_ready_q          <= rs_ready_d;
         rs_rnid_q           <= rs_rnid_d;
         lrq_oh_q            <= lrq_oh_d;
         stq_haz_q           <= stq_haz_d;
         ex2_recv_q          <= ex2_recv_d;
      end
   end

   assign o_valid       = entry_q.valid;
   assign o_state       = entry_q.state;
   assign o_pipe_sel_oh = pipe_sel_q;
   assign o_ex2_recv    = ex2_recv_q;
   assign o_oldest_only = entry_q.oldest_only;

endmodule
